marquee_scan_driver: RTL and testbench

- Upstream index generator and digit multiplexer for the 7-segment character lookup stage.
- Holds a message of character indices and time-multiplexes them across NUM_DIGITS common-anode digits.
- Drives `index` into the lookup stage and captures the returned segment pattern, accounting for the lookup's 1-cycle registered latency.
- Scrolls the message left at a programmable frame rate.

---
 rtl/marquee_scan_driver.sv | 148 ++++++++++++++
 tb/tb_marquee_scan_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/marquee_scan_driver.sv
// Scrolling message scanner: holds character indices, feeds them to the segment
// lookup stage and multiplexes the returned patterns across common-anode digits.
module marquee_scan_driver #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned MSG_LEN       = 32,
    parameter int unsigned SCAN_DIV      = 50000,
    parameter int unsigned SCROLL_FRAMES = 200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [6:0]                 wr_data,
    input  logic [$clog2(MSG_LEN):0]   msg_len,
    input  logic                       scroll_en,
    output logic [6:0]                 index,
    input  logic [6:0]                 seg_in,
    output logic [6:0]                 seg_out,
    output logic [NUM_DIGITS-1:0]      dig_sel,
    output logic                       frame_done
);
    localparam int unsigned AW        = $clog2(MSG_LEN);
    localparam int unsigned LW        = AW + 1;
    localparam int unsigned DW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW        = $clog2(SCAN_DIV);
    localparam int unsigned FW        = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam int unsigned SW        = ((AW > DW) ? AW : DW) + 1;
    localparam int unsigned HOLD_LAST = SCAN_DIV - 4;

    typedef enum logic [1:0] {ST_BLANK, ST_WAIT, ST_LATCH, ST_HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   digit_q, digit_d;
    logic [LW-1:0]   len_q, len_d;
    logic [AW-1:0]   offset_q, offset_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [6:0]      index_d, seg_d;
    logic [NUM_DIGITS-1:0] dig_d;
    logic            done_d;
    logic [LW-1:0]   len_clamp;
    logic [SW-1:0]   pos;
    logic [6:0]      char_c;
    logic [6:0]      msg_buf [MSG_LEN];

    assign len_clamp = (32'(msg_len) > MSG_LEN) ? LW'(MSG_LEN) : msg_len;

    // Next-state, scroll bookkeeping and next registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        len_d    = len_q;
        offset_d = offset_q;
        fcnt_d   = fcnt_q;
        index_d  = index;
        seg_d    = seg_out;
        dig_d    = dig_sel;
        done_d   = 1'b0;
        pos      = '0;
        char_c   = '0;

        // frame_done marks the final cycle of the frame, so it doubles as the boundary strobe
        if (frame_done) begin
            len_d = len_clamp;
            if ((32'(len_clamp) <= NUM_DIGITS) || (LW'(offset_q) >= len_clamp)) begin
                offset_d = '0;
                fcnt_d   = '0;
            end else if (scroll_en) begin
                if (fcnt_q == FW'(SCROLL_FRAMES - 1)) begin
                    fcnt_d   = '0;
                    offset_d = ((LW'(offset_q) + LW'(1)) == len_clamp) ? '0 : offset_q + AW'(1);
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end

        case (state_q)
            ST_BLANK: state_d = ST_WAIT;
            ST_WAIT: begin
                state_d = ST_LATCH;
                seg_d   = seg_in;
                dig_d   = ~(NUM_DIGITS'(1) << digit_q);
            end
            ST_LATCH: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD_LAST)) begin
                    state_d = ST_BLANK;
                    digit_d = (digit_q == DW'(NUM_DIGITS - 1)) ? '0 : digit_q + DW'(1);
                    dig_d   = '1;
                    seg_d   = 7'h7F;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // Character for the digit about to blank, using post-boundary length/offset.
        if (len_d == '0) begin
            char_c = '0;
        end else if (32'(len_d) <= NUM_DIGITS) begin
            char_c = (32'(digit_d) < 32'(len_d)) ? msg_buf[AW'(digit_d)] : 7'd0;
        end else begin
            pos = SW'(offset_d) + SW'(digit_d);
            if (pos >= SW'(len_d)) pos = pos - SW'(len_d);
            char_c = msg_buf[AW'(pos)];
        end

        if ((state_q == ST_HOLD) && (state_d == ST_BLANK)) index_d = char_c;

        done_d = (state_d == ST_HOLD) && (cnt_d == CW'(HOLD_LAST)) &&
                 (digit_q == DW'(NUM_DIGITS - 1));
    end

    // State, scan bookkeeping, outputs and message buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            digit_q    <= '0;
            len_q      <= '0;
            offset_q   <= '0;
            fcnt_q     <= '0;
            index      <= '0;
            seg_out    <= 7'h7F;
            dig_sel    <= '1;
            frame_done <= 1'b0;
            for (int unsigned i = 0; i < MSG_LEN; i++) msg_buf[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            len_q      <= len_d;
            offset_q   <= offset_d;
            fcnt_q     <= fcnt_d;
            index      <= index_d;
            seg_out    <= seg_d;
            dig_sel    <= dig_d;
            frame_done <= done_d;
            if (wr_en && (32'(wr_addr) < MSG_LEN)) msg_buf[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_marquee_scan_driver.sv
// Directed bench for marquee_scan_driver with a small registered lookup-stage model.
module tb_marquee_scan_driver;
    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned MSG_LEN       = 8;
    localparam int unsigned SCAN_DIV      = 8;
    localparam int unsigned SCROLL_FRAMES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic [3:0] msg_len = '0;
    logic       scroll_en = 1'b0;
    logic [6:0] index;
    logic [6:0] seg_in = 7'h7F;
    logic [6:0] seg_out;
    logic [3:0] dig_sel;
    logic       frame_done;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [3:0] len_pending = '0;
    logic [6:0] cap_idx [4];
    logic [6:0] cap_seg [4];

    marquee_scan_driver #(
        .NUM_DIGITS(NUM_DIGITS), .MSG_LEN(MSG_LEN),
        .SCAN_DIV(SCAN_DIV), .SCROLL_FRAMES(SCROLL_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .scroll_en(scroll_en), .index(index), .seg_in(seg_in),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Hand table of the lookup stage (active-low patterns).
    function automatic logic [6:0] lut(input logic [6:0] i);
        case (i)
            7'd0:    return 7'h7F;
            7'd2:    return 7'b1110011;
            7'd3:    return 7'b0100100;
            7'd4:    return 7'b0100001;
            default: return ~i;
        endcase
    endfunction

    always_ff @(posedge clk) seg_in <= lut(index);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame_done(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 100);
        check({tag, " frame_done seen"}, 32'(frame_done), 32'd1);
    endtask

    // Steps one whole frame from a frame_done cycle to the next, capturing each LATCH.
    task automatic scan_frame(input bit full, input string tag);
        int p, slot, d;
        logic [3:0] exp_dig;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n == 1) msg_len = len_pending;
            p = n - 1;
            slot = p % 8;
            d = p / 8;
            exp_dig = (slot < 2) ? 4'hF : 4'(~(4'b0001 << d));
            if (slot == 2) begin
                cap_idx[d] = index;
                cap_seg[d] = seg_out;
            end
            if (full || slot == 2)
                check($sformatf("%s p%0d dig_sel", tag, p), 32'(dig_sel), 32'(exp_dig));
            if (full) begin
                check($sformatf("%s p%0d frame_done", tag, p), 32'(frame_done), 32'(p == 31));
                if (slot < 2) check($sformatf("%s p%0d blank seg", tag, p), 32'(seg_out), 32'h7F);
            end else if (n == 32) begin
                check({tag, " frame_done"}, 32'(frame_done), 32'd1);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s d%0d index", tag, d), 32'(cap_idx[d]), 32'(e[d]));
            check($sformatf("%s d%0d seg", tag, d), 32'(cap_seg[d]), 32'(lut(7'(e[d]))));
        end
    endtask

    initial begin
        int offs [19];
        int off;
        offs = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0, 0, 1, 1, 2, 2, 3};

        // 1: reset, idle with empty message
        step(3);
        check("rst seg_out", 32'(seg_out), 32'h7F);
        check("rst dig_sel", 32'(dig_sel), 32'hF);
        check("rst index", 32'(index), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        step(30);
        check("t1 first frame_done early", 32'(frame_done), 32'd0);
        step(1);
        check("t1 first frame_done", 32'(frame_done), 32'd1);
        for (int f = 0; f < 2; f++) begin
            scan_frame(1'b1, $sformatf("t1 f%0d", f));
            check_frame($sformatf("t1 f%0d", f), 0, 0, 0, 0);
        end

        // 2: short message, no scrolling
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 7'd2; step(1);
        wr_addr = 3'd1; wr_data = 7'd3; step(1);
        wr_addr = 3'd2; wr_data = 7'd4; step(1);
        wr_en = 1'b0;
        msg_len = 4'd3; len_pending = 4'd3; scroll_en = 1'b1;
        wait_frame_done("t2");
        for (int f = 0; f < 10; f++) begin
            scan_frame(1'b0, $sformatf("t2 f%0d", f));
            check_frame($sformatf("t2 f%0d", f), 2, 3, 4, 0);
        end

        // 3 and 4: six-character scroll, then shrink at offset 3
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 7'(i + 1); step(1);
        end
        wr_en = 1'b0;
        wait_frame_done("t3");
        len_pending = 4'd6;
        for (int f = 0; f < 19; f++) begin
            if (f == 18) len_pending = 4'd3;
            scan_frame(1'b0, $sformatf("t3 f%0d", f));
            off = offs[f];
            if (f == 0) check_frame("t3 f0", 1, 2, 3, 0);
            else check_frame($sformatf("t3 f%0d", f), ((off + 0) % 6) + 1, ((off + 1) % 6) + 1,
                             ((off + 2) % 6) + 1, ((off + 3) % 6) + 1);
        end
        scan_frame(1'b0, "t4");
        check_frame("t4", 1, 2, 3, 0);

        // 5: write to the slot currently on display
        step(12);
        check("t5 hold dig_sel", 32'(dig_sel), 32'b1101);
        check("t5 hold index", 32'(index), 32'd2);
        check("t5 hold seg", 32'(seg_out), 32'(lut(7'd2)));
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 7'd5;
        for (int i = 0; i < 4; i++) begin
            step(1);
            wr_en = 1'b0;
            check($sformatf("t5 seg stable %0d", i), 32'(seg_out), 32'(lut(7'd2)));
        end
        step(16);
        check("t5 frame_done", 32'(frame_done), 32'd1);
        scan_frame(1'b0, "t5 next");
        check_frame("t5 next", 1, 5, 3, 0);

        // 6: reset in the middle of a scrolling HOLD
        len_pending = 4'd6;
        scan_frame(1'b0, "t6 a");
        check_frame("t6 a", 1, 5, 3, 0);
        scan_frame(1'b0, "t6 b");
        check_frame("t6 b", 1, 5, 3, 4);
        step(12);
        check("t6 pre dig_sel", 32'(dig_sel), 32'b1101);
        check("t6 pre seg", 32'(seg_out), 32'(lut(7'd3)));
        rst_n = 1'b0;
        step(1);
        check("t6 rst dig_sel", 32'(dig_sel), 32'hF);
        check("t6 rst seg", 32'(seg_out), 32'h7F);
        check("t6 rst index", 32'(index), 32'd0);
        check("t6 rst frame_done", 32'(frame_done), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        check("t6 d0 latch dig_sel", 32'(dig_sel), 32'b1110);
        check("t6 d0 latch seg", 32'(seg_out), 32'h7F);
        step(28);
        check("t6 frame_done early", 32'(frame_done), 32'd0);
        step(1);
        check("t6 frame_done", 32'(frame_done), 32'd1);
        scan_frame(1'b0, "t6 null");
        check_frame("t6 null", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
